// File: rtl/full_adder_ha_pkg.sv
// Shared constants for the half-adder based ripple adder.
// Holds the default operand width and the upper bound used by the width check.
package full_adder_ha_pkg;

  localparam int unsigned FA_DEFAULT_WIDTH = 1;
  localparam int unsigned FA_MAX_WIDTH     = 64;

endpackage

// File: rtl/half_adder.sv
// Combinational half-adder cell: the only arithmetic primitive in the adder.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/full_adder_ha.sv
// Registered WIDTH-bit ripple-carry adder built from half-adder pairs, 1-cycle latency.
// Defining FULL_ADDER_HA_OVF_EN adds the registered signed-overflow output ovf.
module full_adder_ha
  import full_adder_ha_pkg::*;
#(
  parameter int unsigned WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef FULL_ADDER_HA_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH == 0 || WIDTH > FA_MAX_WIDTH) begin : gen_width_check
    $error("full_adder_ha: WIDTH must be within 1..64");
  end

  // carry[i] is the carry into slice i; carry[WIDTH] is the final carry out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] ha1_s, ha1_c, ha2_s, ha2_c;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_slice
    half_adder u_ha1 (
      .x(a[i]),
      .y(b[i]),
      .s(ha1_s[i]),
      .c(ha1_c[i])
    );

    half_adder u_ha2 (
      .x(ha1_s[i]),
      .y(carry[i]),
      .s(ha2_s[i]),
      .c(ha2_c[i])
    );

    assign carry[i+1] = ha1_c[i] | ha2_c[i];
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             valid_d, valid_q;

  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = ha2_s;
      cout_d = carry[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

`ifdef FULL_ADDER_HA_OVF_EN
  // Signed overflow: carry into the MSB slice disagrees with carry out of it.
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = carry[WIDTH-1] ^ carry[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_ha.sv
// Self-checking bench: three adder instances (WIDTH 1, 8, 64) against an arithmetic model.
module tb_full_adder_ha;

  localparam int NL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] a_v   [NL];
  logic [63:0] b_v   [NL];
  logic        cin_v [NL];
  logic        iv_v  [NL];
  logic        cout_v[NL];
  logic        ov_v  [NL];
  logic [0:0]  sum1;
  logic [7:0]  sum8;
  logic [63:0] sum64;

  logic [63:0] exp_sum  [NL];
  logic        exp_cout [NL];
  logic        exp_valid[NL];

  int n_checks = 0;
  int n_fails  = 0;

`ifdef FULL_ADDER_HA_OVF_EN
  logic ovf_v  [NL];
  logic exp_ovf[NL];
`endif

  full_adder_ha #(.WIDTH(1)) u_w1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a_v[0][0:0]),
    .b        (b_v[0][0:0]),
    .cin      (cin_v[0]),
    .in_valid (iv_v[0]),
    .sum      (sum1),
    .cout     (cout_v[0]),
    .out_valid(ov_v[0])
`ifdef FULL_ADDER_HA_OVF_EN
    ,
    .ovf      (ovf_v[0])
`endif
  );

  full_adder_ha #(.WIDTH(8)) u_w8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a_v[1][7:0]),
    .b        (b_v[1][7:0]),
    .cin      (cin_v[1]),
    .in_valid (iv_v[1]),
    .sum      (sum8),
    .cout     (cout_v[1]),
    .out_valid(ov_v[1])
`ifdef FULL_ADDER_HA_OVF_EN
    ,
    .ovf      (ovf_v[1])
`endif
  );

  full_adder_ha #(.WIDTH(64)) u_w64 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a_v[2]),
    .b        (b_v[2]),
    .cin      (cin_v[2]),
    .in_valid (iv_v[2]),
    .sum      (sum64),
    .cout     (cout_v[2]),
    .out_valid(ov_v[2])
`ifdef FULL_ADDER_HA_OVF_EN
    ,
    .ovf      (ovf_v[2])
`endif
  );

  function automatic int lane_w(input int l);
    return (l == 0) ? 1 : ((l == 1) ? 8 : 64);
  endfunction

  function automatic logic [63:0] lane_mask(input int l);
    int w = lane_w(l);
    return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] lane_sum(input int l);
    return (l == 0) ? 64'(sum1) : ((l == 1) ? 64'(sum8) : sum64);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      exp_sum[l]   = '0;
      exp_cout[l]  = 1'b0;
      exp_valid[l] = 1'b0;
`ifdef FULL_ADDER_HA_OVF_EN
      exp_ovf[l]   = 1'b0;
`endif
    end
  endtask

  // Reference: plain (WIDTH+1)-bit addition; overflow from operand/result sign bits.
  task automatic model_edge();
    logic [64:0] full;
    logic [63:0] m;
    int          w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int l = 0; l < NL; l++) begin
      exp_valid[l] = iv_v[l];
      if (iv_v[l] === 1'b1) begin
        w    = lane_w(l);
        m    = lane_mask(l);
        full = {1'b0, a_v[l] & m} + {1'b0, b_v[l] & m} + 65'(cin_v[l]);
        exp_sum[l]  = full[63:0] & m;
        exp_cout[l] = full[w];
`ifdef FULL_ADDER_HA_OVF_EN
        exp_ovf[l]  = (a_v[l][w-1] == b_v[l][w-1]) && (exp_sum[l][w-1] != a_v[l][w-1]);
`endif
      end
    end
  endtask

  task automatic check_lanes(input string tag);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("%s_w%0d_sum", tag, lane_w(l)), lane_sum(l), exp_sum[l]);
      chk($sformatf("%s_w%0d_cout", tag, lane_w(l)), 64'(cout_v[l]), 64'(exp_cout[l]));
      chk($sformatf("%s_w%0d_valid", tag, lane_w(l)), 64'(ov_v[l]), 64'(exp_valid[l]));
`ifdef FULL_ADDER_HA_OVF_EN
      chk($sformatf("%s_w%0d_ovf", tag, lane_w(l)), 64'(ovf_v[l]), 64'(exp_ovf[l]));
`endif
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_lanes(tag);
  endtask

  task automatic set_lane(input int l, input logic [63:0] a, input logic [63:0] b,
                          input logic c, input logic iv);
    a_v[l]   = a;
    b_v[l]   = b;
    cin_v[l] = c;
    iv_v[l]  = iv;
  endtask

  task automatic idle_all();
    for (int l = 0; l < NL; l++) iv_v[l] = 1'b0;
  endtask

  logic [1:0] tbl[8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    logic [2:0] vb;
    for (int l = 0; l < NL; l++) set_lane(l, '0, '0, 1'b0, 1'b0);
    model_reset();

    #12;
    check_lanes("reset");
    rst_n = 1'b1;

    // WIDTH=1 truth table, a is the MSB of the index.
    for (int v = 0; v < 8; v++) begin
      vb = v[2:0];
      set_lane(0, 64'(vb[2]), 64'(vb[1]), vb[0], 1'b1);
      tick("w1_exh");
      chk($sformatf("w1_table_%0d", v), 64'({cout_v[0], sum1}), 64'(tbl[v]));
    end
    idle_all();

    set_lane(1, 64'hFF, 64'h00, 1'b1, 1'b1);
    tick("w8_wrap");
    chk("w8_wrap_sum", 64'(sum8), 64'h00);
    chk("w8_wrap_cout", 64'(cout_v[1]), 64'd1);

    set_lane(1, 64'hFF, 64'hFF, 1'b1, 1'b1);
    tick("w8_ones");
    chk("w8_ones_sum", 64'(sum8), 64'hFF);
    chk("w8_ones_cout", 64'(cout_v[1]), 64'd1);

    set_lane(1, 64'h7F, 64'h01, 1'b0, 1'b1);
    tick("w8_posovf");
    chk("w8_posovf_sum", 64'(sum8), 64'h80);
    chk("w8_posovf_cout", 64'(cout_v[1]), 64'd0);
`ifdef FULL_ADDER_HA_OVF_EN
    chk("w8_posovf_ovf", 64'(ovf_v[1]), 64'd1);
`endif

    set_lane(1, 64'h80, 64'h80, 1'b0, 1'b1);
    tick("w8_negovf");
    chk("w8_negovf_sum", 64'(sum8), 64'h00);
    chk("w8_negovf_cout", 64'(cout_v[1]), 64'd1);
`ifdef FULL_ADDER_HA_OVF_EN
    chk("w8_negovf_ovf", 64'(ovf_v[1]), 64'd1);
`endif

    set_lane(1, 64'h12, 64'h34, 1'b0, 1'b1);
    tick("w8_load");
    chk("w8_load_sum", 64'(sum8), 64'h46);
    chk("w8_load_valid", 64'(ov_v[1]), 64'd1);

    // Idle inputs are random, and X on one cycle; held outputs must not move.
    for (int k = 0; k < 3; k++) begin
      set_lane(1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()), 1'b0);
      if (k == 1) begin
        a_v[1]   = 'x;
        b_v[1]   = 'x;
        cin_v[1] = 1'bx;
      end
      tick("w8_hold");
      chk("w8_hold_sum", 64'(sum8), 64'h46);
      chk("w8_hold_valid", 64'(ov_v[1]), 64'd0);
    end

    set_lane(1, 64'h12, 64'h34, 1'b0, 1'b1);
    tick("w8_reload");
    chk("w8_reload_valid", 64'(ov_v[1]), 64'd1);

    // Asynchronous reset between edges, with no clock edge involved.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sum", 64'(sum8), 64'h00);
    chk("async_rst_cout", 64'(cout_v[1]), 64'd0);
    chk("async_rst_valid", 64'(ov_v[1]), 64'd0);
    model_reset();
    set_lane(1, 64'h01, 64'h01, 1'b0, 1'b1);
    #1;
    rst_n = 1'b1;
    tick("post_rst");
    chk("post_rst_sum", 64'(sum8), 64'h02);
    chk("post_rst_valid", 64'(ov_v[1]), 64'd1);

    for (int n = 0; n < 10000; n++) begin
      for (int l = 0; l < NL; l++) begin
        set_lane(l, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()),
                 $urandom_range(0, 9) != 0);
        if ($urandom_range(0, 15) == 0) a_v[l] = {64{1'b1}};
        if ($urandom_range(0, 15) == 0) b_v[l] = {64{1'b1}};
      end
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
